// File: rtl/dds_pkg.sv
// Shared widths and quadrant encoding for the DDS phase/sine generator.
package dds_pkg;

  localparam int ACC_W_DEF  = 24;
  localparam int LUT_AW_DEF = 8;
  localparam int M_DEF      = 12;
  localparam int FRAME_DEF  = 15;
  localparam int PW_DEF     = LUT_AW_DEF + 2;

  // Top two phase bits select the quadrant: bit 0 mirrors the index, bit 1 negates.
  typedef enum logic [1:0] {
    QUAD_0 = 2'b00,
    QUAD_1 = 2'b01,
    QUAD_2 = 2'b10,
    QUAD_3 = 2'b11
  } quad_e;

  localparam int QUAD_MIRROR_BIT = 0;
  localparam int QUAD_SIGN_BIT   = 1;

endpackage

// File: rtl/sine_quarter_rom.sv
// Combinational quarter-wave sine table, sampled at half-step offsets so the
// quadrant seams never repeat the zero or the peak.
module sine_quarter_rom #(
  parameter int LUT_AW = 8,
  parameter int M      = 12
) (
  input  logic [LUT_AW-1:0] addr,
  output logic [M-1:0]      mag
);

  localparam int  DEPTH = 2 ** LUT_AW;
  localparam real PI    = 3.14159265358979323846;

  function automatic logic [DEPTH*M-1:0] gen_rom();
    logic [DEPTH*M-1:0] t;
    real                ang;
    int                 v;
    t = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ang = (PI / 2.0) * (real'(i) + 0.5) / real'(DEPTH);
      v   = int'(real'((2 ** M) - 1) * $sin(ang));
      t[i*M +: M] = v[M-1:0];
    end
    return t;
  endfunction

  localparam logic [DEPTH*M-1:0] ROM = gen_rom();

  assign mag = ROM[int'(addr)*M +: M];

endmodule

// File: rtl/dds_phase_gen.sv
// Phase accumulator advanced once per frame, folded into a quarter-wave lookup
// that yields an unsigned magnitude plus a sign bit, held for the whole frame.
module dds_phase_gen
  import dds_pkg::*;
#(
  parameter int ACC_W  = ACC_W_DEF,
  parameter int LUT_AW = LUT_AW_DEF,
  parameter int M      = M_DEF,
  parameter int FRAME  = FRAME_DEF,
  localparam int PW    = LUT_AW + 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [ACC_W-1:0] ftw,
  input  logic             ftw_load,
  input  logic [PW-1:0]    phase_ofs,
  output logic [M-1:0]     sample,
  output logic             sample_neg,
  output logic             sample_strobe
);

  localparam int CNT_W = (FRAME > 1) ? $clog2(FRAME) : 1;

  if (FRAME < 3) begin : g_frame_chk
    $error("dds_phase_gen: FRAME must be at least 3");
  end

  logic [CNT_W-1:0]  r_cnt;
  logic [ACC_W-1:0]  r_ftw;
  logic [ACC_W-1:0]  r_acc;
  logic              r_tick_p0;
  logic [LUT_AW-1:0] r_addr_p1;
  logic              r_neg_p1;
  logic              r_v1_p1;
  logic [M-1:0]      r_sample_p2;
  logic              r_neg_p2;
  logic              r_strobe_p2;

  logic              w_tick;
  logic [PW-1:0]     w_phase;
  quad_e             w_quad;
  logic [LUT_AW-1:0] w_idx;
  logic [LUT_AW-1:0] w_addr;
  logic [M-1:0]      w_mag;

  assign w_tick = en && (r_cnt == CNT_W'(FRAME - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= (r_cnt == CNT_W'(FRAME - 1)) ? '0 : r_cnt + CNT_W'(1);
    end
  end

  // A load coinciding with a tick still lets that tick use the previous word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ftw     <= '0;
      r_acc     <= '0;
      r_tick_p0 <= 1'b0;
    end else begin
      if (ftw_load) r_ftw <= ftw;
      if (w_tick)   r_acc <= r_acc + r_ftw;
      r_tick_p0 <= w_tick;
    end
  end

  // Stage 1: offset the phase and fold it into a quarter-wave address.
  assign w_phase = r_acc[ACC_W-1 -: PW] + phase_ofs;
  assign w_quad  = quad_e'(w_phase[PW-1 -: 2]);
  assign w_idx   = w_phase[PW-3:0];
  assign w_addr  = w_quad[QUAD_MIRROR_BIT] ? ~w_idx : w_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr_p1 <= '0;
      r_neg_p1  <= 1'b0;
      r_v1_p1   <= 1'b0;
    end else begin
      if (r_tick_p0) begin
        r_addr_p1 <= w_addr;
        r_neg_p1  <= w_quad[QUAD_SIGN_BIT];
      end
      r_v1_p1 <= r_tick_p0;
    end
  end

  sine_quarter_rom #(
    .LUT_AW(LUT_AW),
    .M     (M)
  ) u_rom (
    .addr(r_addr_p1),
    .mag (w_mag)
  );

  // Stage 2: register the table output; held until the next strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sample_p2 <= '0;
      r_neg_p2    <= 1'b0;
      r_strobe_p2 <= 1'b0;
    end else begin
      if (r_v1_p1) begin
        r_sample_p2 <= w_mag;
        r_neg_p2    <= r_neg_p1;
      end
      r_strobe_p2 <= r_v1_p1;
    end
  end

  assign sample        = r_sample_p2;
  assign sample_neg    = r_neg_p2;
  assign sample_strobe = r_strobe_p2;

endmodule

// File: tb/tb_dds_phase_gen.sv
// Directed bench for dds_phase_gen with default parameters.
module tb_dds_phase_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [23:0] ftw = '0;
  logic        ftw_load = 1'b0;
  logic [9:0]  phase_ofs = '0;
  logic [11:0] sample;
  logic        sample_neg;
  logic        sample_strobe;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dds_phase_gen dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .ftw          (ftw),
    .ftw_load     (ftw_load),
    .phase_ofs    (phase_ofs),
    .sample       (sample),
    .sample_neg   (sample_neg),
    .sample_strobe(sample_strobe)
  );

  // Counts rising edges until a strobe is seen; -1 when the budget runs out.
  task automatic wait_strobe(input int max_edges, output int n);
    n = -1;
    for (int k = 1; k <= max_edges; k++) begin
      @(posedge clk);
      #1;
      if (sample_strobe) begin
        n = k;
        return;
      end
    end
  endtask

  // Reset, load a tuning word and offset while idle, then enable.
  task automatic start(input logic [23:0] f, input logic [9:0] ofs);
    @(negedge clk);
    rst = 1'b1; en = 1'b0; ftw_load = 1'b0;
    @(negedge clk);
    rst = 1'b0; ftw = f; ftw_load = 1'b1; phase_ofs = ofs;
    @(negedge clk);
    ftw_load = 1'b0; en = 1'b1;
  endtask

  task automatic test_reset();
    #3 rst = 1'b1;
    #1;
    n_cmp++; if (sample !== 12'd0) begin n_err++; $display("FAIL reset_sample got %0d want 0", sample); end
    n_cmp++; if (sample_neg !== 1'b0) begin n_err++; $display("FAIL reset_neg got %b want 0", sample_neg); end
    n_cmp++; if (sample_strobe !== 1'b0) begin n_err++; $display("FAIL reset_strobe got %b want 0", sample_strobe); end
  endtask

  task automatic test_zero_ftw();
    int n;
    @(negedge clk);
    rst = 1'b1; ftw = '0; ftw_load = 1'b1; phase_ofs = '0;
    @(negedge clk);
    rst = 1'b0; en = 1'b1; ftw_load = 1'b0;
    wait_strobe(30, n);
    n_cmp++; if (n !== 17) begin n_err++; $display("FAIL zero_first_latency got %0d want 17", n); end
    n_cmp++; if (sample !== 12'd13) begin n_err++; $display("FAIL zero_sample got %0d want 13", sample); end
    n_cmp++; if (sample_neg !== 1'b0) begin n_err++; $display("FAIL zero_neg got %b want 0", sample_neg); end
    wait_strobe(30, n);
    n_cmp++; if (n !== 15) begin n_err++; $display("FAIL zero_period got %0d want 15", n); end
    n_cmp++; if (sample !== 12'd13 || sample_neg !== 1'b0) begin
      n_err++; $display("FAIL zero_sample2 got %0d/%b want 13/0", sample, sample_neg); end
  endtask

  task automatic test_quarter_steps();
    int          n;
    logic [11:0] exp_mag [4];
    logic        exp_neg [4];
    exp_mag = '{12'd4095, 12'd13, 12'd4095, 12'd13};
    exp_neg = '{1'b0, 1'b1, 1'b1, 1'b0};
    start(24'h400000, 10'h000);
    for (int s = 0; s < 8; s++) begin
      wait_strobe(30, n);
      if (s > 0) begin
        n_cmp++; if (n !== 15) begin n_err++; $display("FAIL quarter_period[%0d] got %0d want 15", s, n); end
      end
      n_cmp++; if (sample !== exp_mag[s%4] || sample_neg !== exp_neg[s%4]) begin
        n_err++;
        $display("FAIL quarter_sample[%0d] got %0d/%b want %0d/%b", s, sample, sample_neg, exp_mag[s%4], exp_neg[s%4]);
      end
    end
  endtask

  task automatic test_phase_offset();
    int n;
    start(24'h000000, 10'h100);
    wait_strobe(30, n);
    n_cmp++; if (sample !== 12'd4095 || sample_neg !== 1'b0) begin
      n_err++; $display("FAIL ofs_100 got %0d/%b want 4095/0", sample, sample_neg); end
    @(negedge clk);
    phase_ofs = 10'h3FF;
    repeat (5) @(posedge clk);
    #1;
    n_cmp++; if (sample !== 12'd4095 || sample_neg !== 1'b0) begin
      n_err++; $display("FAIL ofs_hold got %0d/%b want 4095/0", sample, sample_neg); end
    wait_strobe(30, n);
    n_cmp++; if (sample !== 12'd13 || sample_neg !== 1'b1) begin
      n_err++; $display("FAIL ofs_3ff got %0d/%b want 13/1", sample, sample_neg); end
  endtask

  task automatic test_load_on_tick();
    int n;
    start(24'h400000, 10'h000);
    wait_strobe(30, n);
    n_cmp++; if (sample !== 12'd4095 || sample_neg !== 1'b0) begin
      n_err++; $display("FAIL lot_first got %0d/%b want 4095/0", sample, sample_neg); end
    // Next tick edge is 13 edges after this strobe edge.
    repeat (12) @(posedge clk);
    @(negedge clk);
    ftw = 24'h000000; ftw_load = 1'b1;
    @(negedge clk);
    ftw_load = 1'b0;
    wait_strobe(30, n);
    n_cmp++; if (n !== 2) begin n_err++; $display("FAIL lot_latency got %0d want 2", n); end
    n_cmp++; if (sample !== 12'd13 || sample_neg !== 1'b1) begin
      n_err++; $display("FAIL lot_tick got %0d/%b want 13/1", sample, sample_neg); end
    for (int s = 0; s < 2; s++) begin
      wait_strobe(30, n);
      n_cmp++; if (n !== 15 || sample !== 12'd13 || sample_neg !== 1'b1) begin
        n_err++; $display("FAIL lot_hold[%0d] got %0d/%b after %0d want 13/1 after 15", s, sample, sample_neg, n); end
    end
  endtask

  task automatic test_enable_gap();
    int n;
    int cnt;
    start(24'h400000, 10'h000);
    wait_strobe(30, n);
    repeat (14) @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    cnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (sample_strobe) cnt++;
    end
    n_cmp++; if (cnt !== 1) begin n_err++; $display("FAIL gap_strobes got %0d want 1", cnt); end
    n_cmp++; if (sample !== 12'd13 || sample_neg !== 1'b1) begin
      n_err++; $display("FAIL gap_inflight got %0d/%b want 13/1", sample, sample_neg); end
    @(negedge clk);
    en = 1'b1;
    wait_strobe(30, n);
    n_cmp++; if (n !== 16) begin n_err++; $display("FAIL gap_resume got %0d want 16", n); end
    n_cmp++; if (sample !== 12'd4095 || sample_neg !== 1'b1) begin
      n_err++; $display("FAIL gap_sample got %0d/%b want 4095/1", sample, sample_neg); end
  endtask

  task automatic test_wrap();
    int n;
    start(24'hFFFFFF, 10'h000);
    wait_strobe(30, n);
    n_cmp++; if (sample !== 12'd13 || sample_neg !== 1'b1) begin
      n_err++; $display("FAIL wrap_first got %0d/%b want 13/1", sample, sample_neg); end
    wait_strobe(30, n);
    n_cmp++; if (sample !== 12'd13 || sample_neg !== 1'b1) begin
      n_err++; $display("FAIL wrap_second got %0d/%b want 13/1", sample, sample_neg); end
  endtask

  task automatic test_async_reset();
    int n;
    int cnt;
    start(24'h000000, 10'h100);
    wait_strobe(30, n);
    repeat (14) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (sample !== 12'd0 || sample_neg !== 1'b0 || sample_strobe !== 1'b0) begin
      n_err++; $display("FAIL arst_outputs got %0d/%b/%b want 0/0/0", sample, sample_neg, sample_strobe); end
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (16) begin
      @(posedge clk);
      #1;
      if (sample_strobe) cnt++;
    end
    n_cmp++; if (cnt !== 0) begin n_err++; $display("FAIL arst_no_strobe got %0d want 0", cnt); end
    wait_strobe(30, n);
    n_cmp++; if (n !== 1 || sample !== 12'd4095) begin
      n_err++; $display("FAIL arst_restart got %0d after %0d want 4095 after 1", sample, n); end
  endtask

  initial begin
    test_reset();
    test_zero_ftw();
    test_quarter_steps();
    test_phase_offset();
    test_load_on_tick();
    test_enable_gap();
    test_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
